// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX FIFOs, all four SPI modes, link bring-up/reset opcodes
// and a sticky RX overflow flag. Everything runs in the clk domain.
module spi_slave_fifo #(
  parameter int FRAME_BITS  = 32,
  parameter int STATUS_BITS = 8,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter logic [STATUS_BITS-1:0] INIT_OPCODE       = 8'h01,
  parameter logic [STATUS_BITS-1:0] LINK_RESET_OPCODE = 8'hFF,
  localparam int PAYLOAD_BITS = FRAME_BITS - STATUS_BITS,
  localparam int TXLW         = $clog2(TX_DEPTH) + 1,
  localparam int RXLW         = $clog2(RX_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    SPI_SCK,
  input  logic                    SPI_SS,
  input  logic                    SPI_MOSI,
  output logic                    SPI_MISO,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [FRAME_BITS-1:0]   rx_data,
  output logic                    linked,
  output logic                    rx_overflow,
  output logic [TXLW-1:0]         tx_level,
  output logic [RXLW-1:0]         rx_level
);
  localparam int CW  = $clog2(FRAME_BITS);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);

  typedef enum logic {S_INIT, S_ACTIVE} state_e;
  state_e state_q;

  logic [1:0] sck_s_q, ss_s_q, mosi_s_q;
  logic       sck_e_q, ss_e_q, mosi_e_q;

  logic                  in_frame_q, start_pend_q, miso_q, ovf_q;
  logic [CW-1:0]         cnt_q;
  logic [FRAME_BITS-2:0] rx_sr_q;
  logic [FRAME_BITS-1:0] tx_sr_q;
  logic [1:0]            sent_q;  // {overflow, tx word present} as sent in the current frame

  logic [PAYLOAD_BITS-1:0] tx_mem_q [TX_DEPTH];
  logic [TXA-1:0]          tx_wr_q, tx_rd_q;
  logic [TXLW-1:0]         tx_cnt_q;
  logic [FRAME_BITS-1:0]   rx_mem_q [RX_DEPTH];
  logic [RXA-1:0]          rx_wr_q, rx_rd_q;
  logic [RXLW-1:0]         rx_cnt_q;

  // SS sync resets low so a reset released mid-frame does not fake a falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_s_q  <= {2{CPOL}};
      sck_e_q  <= CPOL;
      ss_s_q   <= 2'b00;
      ss_e_q   <= 1'b0;
      mosi_s_q <= 2'b00;
      mosi_e_q <= 1'b0;
    end else begin
      sck_s_q  <= {sck_s_q[0], SPI_SCK};
      sck_e_q  <= sck_s_q[1];
      ss_s_q   <= {ss_s_q[0], SPI_SS};
      ss_e_q   <= ss_s_q[1];
      mosi_s_q <= {mosi_s_q[0], SPI_MOSI};
      mosi_e_q <= mosi_s_q[1];
    end
  end

  logic sck_rise, sck_fall, lead_e, trail_e, sample_e, shift_e, ss_fall, ss_rise;
  assign sck_rise = sck_s_q[1] & ~sck_e_q;
  assign sck_fall = ~sck_s_q[1] & sck_e_q;
  assign lead_e   = CPOL ? sck_fall : sck_rise;
  assign trail_e  = CPOL ? sck_rise : sck_fall;
  assign sample_e = CPHA ? trail_e : lead_e;
  assign shift_e  = CPHA ? lead_e : trail_e;
  assign ss_fall  = ~ss_s_q[1] & ss_e_q;
  assign ss_rise  = ss_s_q[1] & ~ss_e_q;

  logic                   act, is_lr, cmpl, start, rx_full;
  logic                   tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_drop;
  logic [FRAME_BITS-1:0]  frame_w, word_w;
  logic [STATUS_BITS-1:0] opc;
  logic [3:0]             stat_w;

  assign act     = (state_q == S_ACTIVE);
  assign frame_w = {mosi_e_q, rx_sr_q};
  assign opc     = frame_w[STATUS_BITS-1:0];
  assign is_lr   = (opc == LINK_RESET_OPCODE);
  assign cmpl    = in_frame_q & sample_e & ~ss_rise & (cnt_q == CW'(FRAME_BITS - 1));
  // Back-to-back frames start one clk after completion so the status sees the updated state
  assign start   = ss_fall | (start_pend_q & in_frame_q & ~ss_rise);
  assign rx_full = (rx_cnt_q == RXLW'(RX_DEPTH));
  assign stat_w  = {ovf_q, act & (tx_cnt_q != '0), ~rx_full, act};

  always_comb begin
    word_w      = '0;
    word_w[3:0] = stat_w;
    if (stat_w[2]) word_w[FRAME_BITS-1:STATUS_BITS] = tx_mem_q[tx_rd_q];
  end

  assign tx_ready = (tx_cnt_q != TXLW'(TX_DEPTH));
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = cmpl & act & sent_q[0];
  assign tx_flush = cmpl & act & is_lr;
  assign rx_valid = (rx_cnt_q != '0);
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_push  = cmpl & act & ~is_lr & (~rx_full | rx_pop);
  assign rx_drop  = cmpl & act & ~is_lr & rx_full & ~rx_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame_q   <= 1'b0;
      cnt_q        <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      sent_q       <= '0;
      start_pend_q <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      start_pend_q <= cmpl;
      if (ss_fall) begin
        in_frame_q <= 1'b1;
        cnt_q      <= '0;
      end else if (ss_rise) begin
        in_frame_q <= 1'b0;
        cnt_q      <= '0;
      end else if (in_frame_q && sample_e) begin
        rx_sr_q <= frame_w[FRAME_BITS-1:1];
        cnt_q   <= cmpl ? '0 : cnt_q + CW'(1);
      end
      if (ss_rise) begin
        miso_q <= 1'b0;
      end else if (start) begin
        sent_q <= stat_w[3:2];
        if (!CPHA && ss_fall) begin
          miso_q  <= word_w[0];
          tx_sr_q <= word_w >> 1;
        end else begin
          tx_sr_q <= word_w;
        end
      end else if (in_frame_q && shift_e) begin
        miso_q  <= tx_sr_q[0];
        tx_sr_q <= tx_sr_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      ovf_q   <= 1'b0;
    end else begin
      if (cmpl) begin
        unique case (state_q)
          S_INIT:   if (opc == INIT_OPCODE) state_q <= S_ACTIVE;
          S_ACTIVE: if (is_lr) state_q <= S_INIT;
          default:  state_q <= S_INIT;
        endcase
      end
      // A fresh drop beats the clear from a frame that reported the flag
      if (rx_drop)                ovf_q <= 1'b1;
      else if (cmpl && sent_q[1]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
    if (rx_push) rx_mem_q[rx_wr_q] <= frame_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TXA'(1);
      if (tx_flush) begin
        tx_rd_q  <= tx_wr_q;
        tx_cnt_q <= TXLW'(tx_push);
      end else begin
        if (tx_pop) tx_rd_q <= tx_rd_q + TXA'(1);
        tx_cnt_q <= tx_cnt_q + TXLW'(tx_push) - TXLW'(tx_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + RXA'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RXA'(1);
      rx_cnt_q <= rx_cnt_q + RXLW'(rx_push) - RXLW'(rx_pop);
    end
  end

  assign SPI_MISO    = miso_q;
  assign rx_data     = rx_valid ? rx_mem_q[rx_rd_q] : '0;
  assign linked      = act;
  assign rx_overflow = ovf_q;
  assign tx_level    = tx_cnt_q;
  assign rx_level    = rx_cnt_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Drives four slaves (modes 0..3) in lockstep from one host sequence; MISO words
// and RX frames are checked against scoreboard queues filled as stimulus is issued.
module tb_spi_slave_fifo;
  logic clk = 1'b0, reset_n = 1'b0;
  logic sck_base = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic tx_valid = 1'b0, rx_ready = 1'b0;
  logic [23:0] tx_data = '0;
  logic [3:0] sck, miso, tx_ready, rx_valid, linked, ovf;
  logic [3:0][31:0] rx_data, got;
  logic [3:0][2:0]  tx_level, rx_level;
  logic [31:0] miso_q[$], rx_q[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    assign sck[m] = (m >= 2) ? ~sck_base : sck_base;
    spi_slave_fifo #(.CPOL(m >= 2), .CPHA(m % 2 == 1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .SPI_SCK(sck[m]), .SPI_SS(ss), .SPI_MOSI(mosi), .SPI_MISO(miso[m]),
      .tx_valid(tx_valid), .tx_ready(tx_ready[m]), .tx_data(tx_data),
      .rx_valid(rx_valid[m]), .rx_ready(rx_ready), .rx_data(rx_data[m]),
      .linked(linked[m]), .rx_overflow(ovf[m]),
      .tx_level(tx_level[m]), .rx_level(rx_level[m]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each bit: MOSI set, 2 clk, leading edge, 4 clk, trailing edge, 2 clk.
  // CPHA=0 slaves are sampled 2 clk after leading, CPHA=1 slaves 2 clk after trailing.
  task automatic frame(input logic [31:0] w, input int nbits);
    ss = 1'b0;
    ticks(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[i];
      ticks(2); sck_base = 1'b1; ticks(2);
      got[0][i] = miso[0]; got[2][i] = miso[2];
      ticks(2); sck_base = 1'b0; ticks(2);
      got[1][i] = miso[1]; got[3][i] = miso[3];
    end
    ticks(6); ss = 1'b1; mosi = 1'b0; ticks(8);
  endtask

  task automatic xfer(input string tag, input logic [31:0] w);
    logic [31:0] e;
    frame(w, 32);
    e = miso_q.pop_front();
    for (int m = 0; m < 4; m++) chk($sformatf("%s_miso[m%0d]", tag, m), got[m], e);
  endtask

  task automatic push_tx(input logic [23:0] d);
    chk("tx_ready", {28'd0, tx_ready}, 32'hF);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      for (int t = 0; t < 50 && rx_valid !== 4'hF; t++) @(negedge clk);
      chk("rx_valid", {28'd0, rx_valid}, 32'hF);
      e = rx_q.pop_front();
      for (int m = 0; m < 4; m++) chk($sformatf("rx_data[m%0d]", m), rx_data[m], e);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    ticks(3);
    chk("rst_miso", {28'd0, miso}, 32'h0);
    chk("rst_tx_ready", {28'd0, tx_ready}, 32'hF);
    chk("rst_flags", {20'd0, rx_valid, linked, ovf}, 32'h0);
    chk("rst_levels", {8'd0, tx_level, rx_level}, 32'h0);
    for (int m = 0; m < 4; m++) chk($sformatf("rst_rx_data[m%0d]", m), rx_data[m], 32'h0);
    reset_n = 1'b1;
    ticks(4);

    // link bring-up
    miso_q.push_back(32'h0000_0002);
    xfer("bringup", 32'h0000_0001);
    chk("linked_up", {28'd0, linked}, 32'hF);
    chk("init_no_rx", {28'd0, rx_valid}, 32'h0);
    miso_q.push_back(32'h0000_0003); rx_q.push_back(32'h1234_5600);
    xfer("active_status", 32'h1234_5600);
    drain(1);

    // TX transfer
    push_tx(24'hCAFE77); push_tx(24'h0000AA);
    chk("tx_level2", {20'd0, tx_level}, {20'd0, {4{3'd2}}});
    miso_q.push_back(32'hCAFE_7707); rx_q.push_back(32'h1111_0010);
    xfer("tx0", 32'h1111_0010);
    chk("tx_level1", {20'd0, tx_level}, {20'd0, {4{3'd1}}});
    miso_q.push_back(32'h0000_AA07); rx_q.push_back(32'h2222_0020);
    xfer("tx1", 32'h2222_0020);
    chk("tx_level0", {20'd0, tx_level}, 32'h0);
    miso_q.push_back(32'h0000_0003); rx_q.push_back(32'h3333_0030);
    xfer("tx_empty", 32'h3333_0030);
    drain(3);

    // RX overflow
    for (int k = 0; k < 4; k++) begin
      miso_q.push_back(32'h0000_0003); rx_q.push_back(32'hA000_0040 + k);
      xfer("ovf_fill", 32'hA000_0040 + k);
    end
    chk("rx_level_full", {20'd0, rx_level}, {20'd0, {4{3'd4}}});
    miso_q.push_back(32'h0000_0001);
    xfer("ovf_drop", 32'hB000_0050);
    chk("ovf_set", {28'd0, ovf}, 32'hF);
    chk("rx_level_kept", {20'd0, rx_level}, {20'd0, {4{3'd4}}});
    miso_q.push_back(32'h0000_0009);
    xfer("ovf_status", 32'hB000_0051);
    chk("ovf_redrop_holds", {28'd0, ovf}, 32'hF);
    drain(4);
    miso_q.push_back(32'h0000_000B); rx_q.push_back(32'hC000_0060);
    xfer("ovf_report", 32'hC000_0060);
    chk("ovf_cleared", {28'd0, ovf}, 32'h0);
    drain(1);

    // aborted frame
    push_tx(24'hABCDEF);
    frame(32'h0000_0042, 12);
    for (int m = 0; m < 4; m++) chk($sformatf("abort_bits[m%0d]", m), got[m] & 32'hFFF, 32'hF07);
    chk("abort_no_rx", {28'd0, rx_valid}, 32'h0);
    chk("abort_tx_kept", {20'd0, tx_level}, {20'd0, {4{3'd1}}});
    miso_q.push_back(32'hABCD_EF07); rx_q.push_back(32'h55AA_0042);
    xfer("abort_resend", 32'h55AA_0042);
    drain(1);
    chk("abort_tx_popped", {20'd0, tx_level}, 32'h0);

    // link reset opcode
    push_tx(24'h000111); push_tx(24'h000222);
    miso_q.push_back(32'h0001_1107);
    xfer("lr_frame", 32'h0000_00FF);
    chk("lr_linked", {28'd0, linked}, 32'h0);
    chk("lr_flush", {20'd0, tx_level}, 32'h0);
    chk("lr_no_rx", {28'd0, rx_valid}, 32'h0);
    miso_q.push_back(32'h0000_0002);
    xfer("relink", 32'h0000_0001);
    chk("relinked", {28'd0, linked}, 32'hF);

    // async reset in the middle of a frame
    push_tx(24'h000333);
    ss = 1'b0; ticks(8); mosi = 1'b1; ticks(2); sck_base = 1'b1; ticks(3);
    chk("pre_rst_miso", {28'd0, miso}, 32'hF);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_miso", {28'd0, miso}, 32'h0);
    chk("arst_flags", {20'd0, rx_valid, linked, ovf}, 32'h0);
    chk("arst_tx", {17'd0, tx_ready, tx_level, 8'd0}, {17'd0, 4'hF, 12'd0, 8'd0});
    @(negedge clk); sck_base = 1'b0; ticks(2);
    reset_n = 1'b1; ticks(4);
    for (int k = 0; k < 4; k++) begin sck_base = ~sck_base; ticks(4); end
    chk("post_rst_idle_miso", {28'd0, miso}, 32'h0);
    chk("post_rst_idle_rx", {25'd0, rx_valid, rx_level[0]}, 32'h0);
    ss = 1'b1; mosi = 1'b0; ticks(8);
    miso_q.push_back(32'h0000_0002);
    xfer("after_rst", 32'h0000_0001);
    chk("after_rst_linked", {28'd0, linked}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_fifo.md
# spi_slave_fifo

Parametrised SPI slave for the FPGA-to-host link, the next generation of the fixed 32-bit single-buffer slave. It adds configurable frame and status widths, a TX FIFO and an RX FIFO with valid/ready handshakes, and all four SPI modes. It also provides a sticky overflow status and a link-reset opcode. It sits between the host SPI pins and the fabric command/data logic, all in the `clk` domain.

## Interface
- `FRAME_BITS`, 32: bits per frame; must be at least `STATUS_BITS+1`.
- `STATUS_BITS`, 8: leading opcode/status field, at least 4.
- `TX_DEPTH`, 4: TX FIFO entries, a power of two, at least 2.
- `RX_DEPTH`, 4: RX FIFO entries, a power of two, at least 2.
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 samples on the leading edge, 1 on the trailing edge.
- `INIT_OPCODE`, 8'h01: opcode that brings the link up.
- `LINK_RESET_OPCODE`, 8'hFF: opcode that drops the link back to INIT.
- Derived: `PAYLOAD_BITS = FRAME_BITS - STATUS_BITS`.
- `clk` in 1: system clock. It must be at least 8x SCK.
- `reset_n` in 1: asynchronous, active-low reset.
- `SPI_SCK`, `SPI_SS`, `SPI_MOSI` in 1: host pins, asynchronous. `SPI_SS` is active-low.
- `SPI_MISO` out 1: registered output.
- `tx_valid` in 1, `tx_ready` out 1, `tx_data` in `PAYLOAD_BITS`: fabric-to-host words.
- `rx_valid` out 1, `rx_ready` in 1, `rx_data` out `FRAME_BITS`: host-to-fabric frames, full frame including the opcode field.
- `linked` out 1: link is in the ACTIVE state.
- `rx_overflow` out 1: sticky overflow flag.
- `tx_level`, `rx_level` out `$clog2(DEPTH)+1`: FIFO occupancy.

## Operation
- **Synchronisers:** SCK, SS and MOSI pass through 2-FF synchronisers plus one edge register each.
  - Leading edge = SCK rising when `CPOL=0`, falling when `CPOL=1`.
  - Sample edge = leading edge if `CPHA=0`, else trailing edge.
  - Shift edge = the other edge.
- **Frame format:** LSB first.
  - Bits `0..STATUS_BITS-1` carry the opcode on MOSI and the status on MISO.
  - Remaining bits carry the payload.
- **Bit counter:**
  - Cleared on either SS edge.
  - Increments on each sample edge while SS is low.
  - On reaching `FRAME_BITS`, the frame completes, the counter returns to 0 and the next frame may follow within the same SS-low window.
- **Frame start** (SS falling edge, or frame completion while SS stays low):
  - Latch the status word: bit0=`linked`, bit1=RX FIFO not full, bit2=TX word present (ACTIVE and TX FIFO non-empty), bit3=`rx_overflow`, upper bits 0.
  - Peek the TX FIFO head into the payload shift register, or load zeros if no TX word is present.
  - When `CPHA=0`, drive bit 0 on MISO at frame start. Thereafter MISO advances one bit per shift edge.
- **Frame completion, INIT state:**
  - If opcode == `INIT_OPCODE`, go to ACTIVE.
  - Nothing is pushed to the RX FIFO or popped from the TX FIFO.
- **Frame completion, ACTIVE state:**
  - Pop the TX FIFO if bit2 was sent.
  - If opcode == `LINK_RESET_OPCODE`, go to INIT and flush the TX FIFO. Nothing is pushed to RX.
  - Otherwise push the frame to RX if the RX FIFO is not full. If it is full, drop the frame and set `rx_overflow`.
- **`rx_overflow` clearing:**
  - Cleared at completion of a frame whose status had bit3=1.
  - A new overflow in that same cycle wins, so the flag stays set.
- **Aborted frame** (SS rises before `FRAME_BITS` bits):
  - Frame discarded.
  - TX FIFO untouched; the peeked word is re-sent in the next frame.
  - Overflow flag unchanged.
- **TX FIFO handshake:**
  - `tx_ready` = not full.
  - A write happens when `tx_valid && tx_ready`.
  - A write is accepted in INIT too, but bit2 reads 0 until the link is ACTIVE.
  - Simultaneous pop and push on a full FIFO is allowed only in the order pop-then-push next cycle; `tx_ready` reflects pre-pop state.
- **RX FIFO handshake:**
  - Standard valid/ready.
  - `rx_data` is stable while `rx_valid && !rx_ready`.
  - Simultaneous push and pop when full is legal: the push succeeds and no overflow is raised.
- **Idle MISO:** 0 while SS is high.

## Timing
- **Reset values:** state INIT, `SPI_MISO`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `linked`=0, `rx_overflow`=0, levels 0, counter 0, FIFOs empty.
- **Reset mid-frame:** reset asserted during a frame aborts it; after release the slave waits for the next SS falling edge.
- **Pin to internal edge:** a pin edge becomes an internal edge 3 `clk` after its synchroniser input changes.
- **`SPI_MISO`** updates 1 `clk` after the internal shift edge (or after the internal SS falling edge for bit 0 with `CPHA=0`).
- **`rx_valid`** rises 1 `clk` after the internal sample edge of the last bit.
- **`linked`** changes on the same cycle as `rx_valid` would.
- **`tx_level`** decrements 1 `clk` after frame completion.

## Test plan
- **Link bring-up:**
  - Stimulus: mode 0, reset, then frame 0x00000001.
  - Required: MISO status reads 0x02 (bit1 set); `linked` rises; `rx_valid` stays 0.
  - Next frame 0x12345600: status reads 0x03; `rx_data`=0x12345600.
- **TX transfer:**
  - Stimulus: while linked, push 0xCAFE77 and 0x0000AA, then 3 frames.
  - Required: MISO frames read 0xCAFE7707, 0x0000AA07, 0x00000003; `tx_level` goes 2→1→0.
- **RX overflow:**
  - Stimulus: `RX_DEPTH`=4, `rx_ready`=0, 5 data frames.
  - Required: the 5th frame is dropped; `rx_overflow`=1; status bit3=1 and bit1=0 in the next frame; the flag clears after that frame completes once `rx_ready` frees space.
- **Abort:**
  - Stimulus: queue 0xABCDEF, raise SS after 12 bits, then send a full frame.
  - Required: 0xABCDEF is sent in the full frame; no RX push from the aborted frame.
- **Modes:** repeat the TX transfer scenario for `CPOL`/`CPHA` = 01, 10, 11 with SCK = `clk`/8; results are identical.
- **Link reset and async reset:**
  - Stimulus: an 0xFF opcode frame with 2 TX words queued.
  - Required: `linked`=0; `tx_level`=0.
  - Asserting `reset_n` mid-frame returns all outputs to their reset values immediately, without waiting for `clk`.
